// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the 4-master bus arbiter with slave watchdog.
package bus_arb_pkg;

  localparam int NUM_MASTERS  = 4;
  localparam int MID_W        = 2;
  localparam int DEF_TIMEOUT  = 16;
  localparam int DEF_MAX_HOLD = 64;
  localparam int DEF_CNT_W    = 8;

  typedef logic [MID_W-1:0] mid_t;

  function automatic logic [NUM_MASTERS-1:0] mid_onehot(input mid_t id);
    logic [NUM_MASTERS-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin candidate search: first active request after the current owner.
module bus_rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  mid_t                   i_owner,
  output mid_t                   o_next,
  output logic                   o_valid
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    mid_t cand;
    o_next  = i_owner;
    o_valid = 1'b0;
    cand    = i_owner;
    for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
      cand = i_owner + mid_t'(k);
      if (i_req[cand]) begin
        o_next  = cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_wdt.sv
// Round-robin bus arbiter with owner hold limit and slave-response watchdog.
module bus_arbiter_wdt
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req_,
  input  logic m1_req_,
  input  logic m2_req_,
  input  logic m3_req_,
  output logic m0_grnt_,
  output logic m1_grnt_,
  output logic m2_grnt_,
  output logic m3_grnt_,
  input  logic bus_as_,
  input  logic bus_rdy_,
  output logic bus_tmo_,
  output mid_t tmo_master,
  output logic tmo_sticky,
  input  logic tmo_clr
);

  localparam logic [CNT_W-1:0] LP_HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] LP_TMO_THR  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_SAT  = '1;

  mid_t                   r_owner;
  logic [NUM_MASTERS-1:0] r_grnt_n;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic [CNT_W-1:0]       r_wdt_cnt;
  logic                   r_busy;
  logic                   r_tmo_n;
  mid_t                   r_tmo_master;
  logic                   r_tmo_sticky;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_own_req;
  logic                   w_other_req;
  mid_t                   w_pick_next;
  logic                   w_pick_vld;
  logic                   w_hold_max;
  logic                   w_rotate;
  logic                   w_wdt_run;
  logic                   w_fire;

  assign w_req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_own_req   = w_req[r_owner];
  assign w_other_req = |(w_req & ~mid_onehot(r_owner));
  assign w_hold_max  = (r_hold_cnt == LP_HOLD_MAX);

  bus_rr_pick u_pick (
    .i_req   (w_req),
    .i_owner (r_owner),
    .o_next  (w_pick_next),
    .o_valid (w_pick_vld)
  );

  // Ownership only moves between transfers: not busy and strobe released.
  assign w_rotate  = !r_busy && bus_as_ && w_pick_vld && (!w_own_req || w_hold_max);
  assign w_wdt_run = !bus_as_ && bus_rdy_;
  assign w_fire    = w_wdt_run && (r_wdt_cnt == LP_TMO_THR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner  <= '0;
      r_grnt_n <= ~mid_onehot(mid_t'(0));
    end else if (w_rotate) begin
      r_owner  <= w_pick_next;
      r_grnt_n <= ~mid_onehot(w_pick_next);
    end
  end

  // A timed-out owner is pushed to the limit so it yields as soon as possible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (w_rotate || !w_other_req) begin
      r_hold_cnt <= '0;
    end else if (w_fire) begin
      r_hold_cnt <= LP_HOLD_MAX;
    end else if (w_own_req && (r_hold_cnt != LP_HOLD_MAX)) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdt_cnt <= '0;
    end else if (!w_wdt_run || w_fire) begin
      r_wdt_cnt <= '0;
    end else if (r_wdt_cnt != LP_CNT_SAT) begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else if (!bus_rdy_ || !r_tmo_n) begin
      r_busy <= 1'b0;
    end else if (!bus_as_) begin
      r_busy <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_n      <= 1'b1;
      r_tmo_master <= '0;
      r_tmo_sticky <= 1'b0;
    end else begin
      r_tmo_n <= !w_fire;
      if (w_fire) begin
        r_tmo_master <= r_owner;
        r_tmo_sticky <= 1'b1;
      end else if (tmo_clr) begin
        r_tmo_sticky <= 1'b0;
      end
    end
  end

  assign m0_grnt_   = r_grnt_n[0];
  assign m1_grnt_   = r_grnt_n[1];
  assign m2_grnt_   = r_grnt_n[2];
  assign m3_grnt_   = r_grnt_n[3];
  assign bus_tmo_   = r_tmo_n;
  assign tmo_master = r_tmo_master;
  assign tmo_sticky = r_tmo_sticky;

endmodule
